// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle for fetch_queue: fetch inputs, flush, stall and the decode handshake.
// The queue takes the slave side; the environment feeding it takes the master side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          if_approx;
  logic          flush;
  logic          stall_out;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_pc;
  logic          dec_approx;
  logic [CW-1:0] count;

  modport master (
    output if_instr, if_pc, if_approx, flush, dec_ready,
    input  stall_out, dec_valid, dec_instr, dec_pc, dec_approx, count
  );

  modport slave (
    input  if_instr, if_pc, if_approx, flush, dec_ready,
    output stall_out, dec_valid, dec_instr, dec_pc, dec_approx, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode: generates the fetch stall,
// drops NOPs and the re-presented instruction behind a stall, and empties on a flush.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter bit          DROP_NOP = 1'b1,
  parameter logic [31:0] NOP      = 32'hf0000000
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_mem  [DEPTH];
  logic [31:0]   pc_mem     [DEPTH];
  logic          approx_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          stall_q;

  logic          is_nop;
  logic          enq;
  logic          deq;
  logic          stall_out;
  logic          dec_valid;

  // Fetch reacts to stall one cycle late, so stall at DEPTH-1 leaves room for exactly one straggler.
  assign stall_out = (count_q >= CW'(DEPTH - 1));
  assign dec_valid = (count_q != '0);

  // While stall_q is set, fetch is re-presenting the instruction already captured.
  assign is_nop = DROP_NOP && (bus.if_instr == NOP);
  assign enq    = ~reset & ~bus.flush & ~stall_q & ~is_nop;
  assign deq    = dec_valid & bus.dec_ready;

  assign bus.stall_out  = stall_out;
  assign bus.dec_valid  = dec_valid;
  assign bus.dec_instr  = instr_mem[rd_ptr];
  assign bus.dec_pc     = pc_mem[rd_ptr];
  assign bus.dec_approx = approx_mem[rd_ptr];
  assign bus.count      = count_q;

  always_ff @(posedge clock) begin
    if (enq) begin
      instr_mem[wr_ptr]  <= bus.if_instr;
      pc_mem[wr_ptr]     <= bus.if_pc;
      approx_mem[wr_ptr] <= bus.if_approx;
    end
  end

  // Flush shares the reset path so neither the current input nor a pending dequeue survives it.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      stall_q <= stall_out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(enq && (count_q == CW'(DEPTH))));
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the fetch stage; upstream of decode.
- Captures the fetch stage's per-cycle instruction, PC and predict-taken bit into a small circular FIFO.
- Presents entries to decode through a valid/ready handshake.
- Generates the fetch stall signal. On branch-miss flush it discards everything in flight.

Parameters:
- DEPTH, 4: number of entries. Power of two, minimum 2.
- DROP_NOP, 1: when 1, incoming instructions equal to NOP (32'hf0000000) are not enqueued.
- NOP, 32'hf0000000: NOP encoding used for DROP_NOP matching.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_instr  in  32  instruction from fetch, valid every cycle
- if_pc  in  32  PC of if_instr
- if_approx  in  1  predicted-taken bit from fetch
- flush  in  1  branch mispredict (branch_result.en & branch_result.miss)
- stall_out  out  1  stall request to fetch
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode accepts head this cycle
- dec_instr  out  32  head instruction
- dec_pc  out  32  head PC
- dec_approx  out  1  head predicted-taken bit
- count  out  log2(DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- Interface decision: reset is `reset`, synchronous, active-high; clock is `clock`.
- State:
  - storage array[DEPTH] of {instr, pc, approx};
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrap modulo DEPTH;
  - count, 0..DEPTH;
  - stall_q, a register holding stall_out of the previous cycle.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, stall_q=0. Hence dec_valid=0, stall_out=0, count=0. Storage is not reset.
- stall_out is combinational: 1 when count >= DEPTH-1. Because fetch acts on it one cycle late, at most one further entry arrives after it rises, so the queue never overflows.
- Duplicate suppression: when stall_q=1, fetch is re-presenting the same PC, so the input is ignored.
- enq = ~reset & ~flush & ~stall_q & ~(DROP_NOP & if_instr==NOP).
- deq = dec_valid & dec_ready.
- dec_valid = (count != 0). dec_* are driven from array[rd_ptr].
- Latency: an instruction enqueued in cycle t is visible to decode at t+1 at the earliest. There is no bypass.
- On enq: write array[wr_ptr], then wr_ptr+1.
- On deq: rd_ptr+1.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Simultaneous enq and deq at count=1 is legal: the head advances to the new entry and count stays 1.
- Flush, cycle t (priority over enq and deq):
  - rd_ptr=wr_ptr=0, count=0, stall_q=0 at t+1;
  - if_instr in cycle t is dropped;
  - dec_ready in cycle t is ignored; decode must not consume on flush;
  - the instruction at t+1, which is from flash_addr, is enqueued regardless of prior stall.
- Reset mid-operation: same effect as flush, plus stall_q=0. The input is not enqueued while reset=1.
- Full (count=DEPTH): enq is unreachable by construction. An assertion must fire if enq occurs with count==DEPTH.
- Empty with dec_ready=1: no effect.
- stall_q always registers stall_out, except under reset or flush, where it clears to 0.

Test Plan:
1. Reset, then the sequence pc=0..5 with dec_ready=1 and distinct instrs: dec_pc=0..5 on consecutive cycles, each one cycle after input; stall_out stays 0; count never exceeds 1.
2. DEPTH=4, dec_ready=0, stream pc=0,1,2,3,3,3: stall_out rises when count=3. The pc=3 entry is accepted once and the repeats are ignored. count saturates at 4. Raising dec_ready then drains 0,1,2,3 in order with no duplicates.
3. Queue holding pc 10,11,12 with stall_q=1; assert flush while if_pc=99 (NOP): count=0 next cycle. The next input, pc=40, is enqueued and appears on dec_pc=40 with dec_approx preserved. No 10..12 or 99 entry ever appears.
4. DROP_NOP=1, input sequence A, NOP, B: only A and B are delivered. With DROP_NOP=0, all three are delivered.
5. Wrap-around: push and pop 10 entries with count oscillating between 1 and 2. Order and pc values are preserved across the pointer wrap (rd_ptr 3->0).
6. Assert reset for one cycle with count=3: the next cycle has count=0, dec_valid=0, stall_out=0, and the input present during reset is not enqueued.
